// File: rtl/rgbw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : rgbw_pkg                                               |
// | Description : Shared types and constants for the RGBW intensity      |
// |               scheduler (FSM encoding, channel order, rounding).     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package rgbw_pkg;

  typedef logic [7:0]  chan_t;
  typedef logic [15:0] prod_t;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STORE  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Channel processing order: red, green, blue, white
  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;
  localparam logic [1:0] CH_W = 2'd3;

  localparam int          TIMEOUT_CYC_DEF = 64;
  localparam logic [16:0] ROUND_CONST     = 17'd128;

  // Round-to-nearest divide by 256 with saturation; the 17-bit sum keeps
  // the carry so that a full-scale product clamps instead of wrapping.
  function automatic chan_t scale_product(input prod_t res);
    logic [16:0] sum;
    sum = {1'b0, res} + ROUND_CONST;
    return sum[16] ? 8'hFF : sum[15:8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgbw_mult_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : rgbw_mult_scheduler_if                                 |
// | Description : Control, channel data and shared-multiplier handshake  |
// |               bundle of the RGBW scheduler.                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface rgbw_mult_scheduler_if;
  import rgbw_pkg::*;

  logic  clk_half;
  logic  start;
  chan_t lint;
  chan_t red_in;
  chan_t green_in;
  chan_t blue_in;
  chan_t white_in;

  chan_t mult_a;
  chan_t mult_b;
  logic  mult_ld;
  logic  mult_rdy;
  prod_t mult_res;

  chan_t red_out;
  chan_t green_out;
  chan_t blue_out;
  chan_t white_out;
  logic  busy;
  logic  done;
  logic  err;

  // Environment side: drives requests and the multiplier result
  modport master (
    output clk_half, start, lint, red_in, green_in, blue_in, white_in,
    output mult_rdy, mult_res,
    input  mult_a, mult_b, mult_ld,
    input  red_out, green_out, blue_out, white_out, busy, done, err
  );

  // Scheduler side
  modport slave (
    input  clk_half, start, lint, red_in, green_in, blue_in, white_in,
    input  mult_rdy, mult_res,
    output mult_a, mult_b, mult_ld,
    output red_out, green_out, blue_out, white_out, busy, done, err
  );

endinterface
`default_nettype wire

// File: rtl/rgbw_mult_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rgbw_mult_scheduler                                    |
// | Description : Rescales four RGBW channels by a common intensity      |
// |               factor using one external 8x8 multiplier, one channel  |
// |               at a time, and commits all four results together.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rgbw_mult_scheduler
  import rgbw_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  rgbw_mult_scheduler_if.slave bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  chan_t            lint_q, lint_d;
  logic [3:0][7:0]  snap_q, snap_d;
  logic [3:0][7:0]  shadow_q, shadow_d;
  logic [3:0][7:0]  out_q, out_d;
  chan_t            res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic  bypass;
  chan_t cur_val;
  logic  mult_phase;

  // Factors 0 and 255 are exact without the multiplier (255 would round down)
  assign bypass     = (lint_q == 8'h00) || (lint_q == 8'hFF);
  assign cur_val    = snap_q[idx_q];
  assign mult_phase = ((state_q == ST_LOAD) && !bypass) || (state_q == ST_WAIT);

  // Operands stay parked from LOAD until the result is taken; zero otherwise
  assign bus.mult_a  = mult_phase ? cur_val : 8'h00;
  assign bus.mult_b  = mult_phase ? lint_q  : 8'h00;
  // LOAD may span several clocks when clk_half is slow; pulse only on the enabled one
  assign bus.mult_ld = (state_q == ST_LOAD) && !bypass && bus.clk_half;

  assign bus.red_out   = out_q[CH_R];
  assign bus.green_out = out_q[CH_G];
  assign bus.blue_out  = out_q[CH_B];
  assign bus.white_out = out_q[CH_W];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  // Register bank; asynchronous reset aborts any sequence in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= CH_R;
      lint_q   <= '0;
      snap_q   <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lint_q   <= lint_d;
      snap_q   <= snap_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; everything holds on disabled cycles except done, which self-clears
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lint_d   = lint_q;
    snap_d   = snap_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;

    if (bus.clk_half) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            lint_d  = bus.lint;
            snap_d  = {bus.white_in, bus.blue_in, bus.green_in, bus.red_in};
            idx_d   = CH_R;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_LOAD;
          end
        end

        ST_LOAD: begin
          cnt_d = '0;
          if (bypass) begin
            res_d   = (lint_q == 8'h00) ? 8'h00 : cur_val;
            state_d = ST_STORE;
          end else begin
            state_d = ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (bus.mult_rdy) begin
            res_d   = scale_product(bus.mult_res);
            state_d = ST_STORE;
          end else if (cnt_q == CNT_LAST) begin
            // Abort: committed outputs are left untouched
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_STORE: begin
          shadow_d[idx_q] = res_q;
          if (idx_q == CH_W) begin
            state_d = ST_FINISH;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_LOAD;
          end
        end

        ST_FINISH: begin
          out_d   = shadow_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgbw_mult_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_rgbw_mult_scheduler                                 |
// | Description : Self-checking bench for rgbw_mult_scheduler with an    |
// |               ideal external multiplier and a transaction-level      |
// |               reference model.                                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_rgbw_mult_scheduler;

  localparam int TMO = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  rgbw_mult_scheduler_if bus();

  rgbw_mult_scheduler #(.TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit half_mode = 1'b0;
  bit mute      = 1'b0;
  int force_res = -1;
  bit chk_en    = 1'b0;

  // Transaction-level reference model state
  bit         pend_active = 1'b0;
  bit         pend_tmo    = 1'b0;
  int         pend_end    = 0;
  int         s_cyc       = 0;
  logic [7:0] pend_in  [4];
  logic [7:0] pend_out [4];
  logic [7:0] pend_lint;
  logic [7:0] exp_out  [4];
  bit         exp_err  = 1'b0;
  int         ld_count = 0;
  int         exp_ld   = 0;
  bit         waiting  = 1'b0;
  logic [7:0] hold_a, hold_b;
  int         done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Clock enable: always high, or alternating when half_mode is set
  always @(posedge clk) begin
    #2;
    bus.clk_half = half_mode ? ~bus.clk_half : 1'b1;
  end

  // Ideal multiplier: product valid on the enabled cycle after the load
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mult_rdy <= 1'b0;
      bus.mult_res <= '0;
    end else if (bus.mult_ld) begin
      bus.mult_rdy <= ~mute;
      bus.mult_res <= (force_res >= 0) ? 16'(force_res) : bus.mult_a * bus.mult_b;
    end else if (bus.clk_half) begin
      bus.mult_rdy <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] model_scale(input logic [7:0] x, input logic [7:0] k);
    int p;
    if (k == 8'd0)   return 8'd0;
    if (k == 8'd255) return x;
    p = (force_res >= 0) ? force_res : int'(x) * int'(k);
    p = (p + 128) / 256;
    return (p > 255) ? 8'd255 : 8'(p);
  endfunction

  // Per-cycle comparison of DUT against the model
  always @(negedge clk) begin : p_cmp
    bit exp_done, exp_busy;
    if (reset) begin
      pend_active = 1'b0;
      waiting     = 1'b0;
      exp_err     = 1'b0;
      for (int i = 0; i < 4; i++) exp_out[i] = 8'h00;
      check("reset_state",
            {bus.done, bus.busy, bus.err, bus.mult_ld, bus.mult_a, bus.mult_b,
             bus.red_out, bus.green_out, bus.blue_out, bus.white_out}, 64'd0);
    end else if (chk_en) begin
      exp_done = 1'b0;
      exp_busy = 1'b0;
      if (pend_active) begin
        if (cyc == pend_end) begin
          exp_done = 1'b1;
          exp_err  = pend_tmo;
          if (!pend_tmo) for (int i = 0; i < 4; i++) exp_out[i] = pend_out[i];
          check("mult_ld_count", ld_count, exp_ld);
          pend_active = 1'b0;
          waiting     = 1'b0;
        end else begin
          exp_busy = 1'b1;
          if (waiting) begin
            check("operand_hold", {bus.mult_a, bus.mult_b}, {hold_a, hold_b});
            if (bus.mult_rdy && bus.clk_half) waiting = 1'b0;
          end
          if (bus.mult_ld) begin
            check("operand_load", {bus.mult_a, bus.mult_b},
                  {(ld_count < 4) ? pend_in[ld_count] : 8'h00, pend_lint});
            hold_a   = bus.mult_a;
            hold_b   = bus.mult_b;
            waiting  = 1'b1;
            ld_count++;
          end
        end
      end else begin
        check("stray_mult_ld", bus.mult_ld, 1'b0);
      end
      if (bus.done) done_cyc = cyc;
      check("cycle_state",
            {bus.done, bus.busy, bus.err, bus.red_out, bus.green_out, bus.blue_out, bus.white_out},
            {exp_done, exp_busy, exp_err, exp_out[0], exp_out[1], exp_out[2], exp_out[3]});
    end
  end

  // Issue a start on an enabled cycle and arm the model for it
  task automatic run_txn(input logic [7:0] k, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input logic [7:0] w, input bit tmo);
    int per, len;
    bit byp;
    do begin
      @(negedge clk); #1;
    end while (bus.clk_half !== 1'b1);
    bus.start = 1'b1; bus.lint = k;
    bus.red_in = r; bus.green_in = g; bus.blue_in = b; bus.white_in = w;
    @(posedge clk); #1;
    bus.start = 1'b0;
    // Disturb the live inputs: only the snapshot may be used
    bus.lint = ~k; bus.red_in = ~r; bus.green_in = ~g; bus.blue_in = ~b; bus.white_in = ~w;
    byp  = (k == 8'd0) || (k == 8'd255);
    per  = half_mode ? 2 : 1;
    len  = tmo ? (1 + TMO) : (1 + 4 * (byp ? 2 : 3));
    s_cyc     = cyc;
    pend_end  = s_cyc + len * per;
    pend_in   = '{r, g, b, w};
    pend_lint = k;
    pend_tmo  = tmo;
    ld_count  = 0;
    waiting   = 1'b0;
    exp_ld    = tmo ? 1 : (byp ? 0 : 4);
    for (int i = 0; i < 4; i++) pend_out[i] = model_scale(pend_in[i], k);
    exp_err     = 1'b0;
    done_cyc    = -1;
    pend_active = 1'b1;
  endtask

  task automatic poke_start(input logic [7:0] k, input logic [7:0] v);
    @(negedge clk); #1;
    bus.start = 1'b1; bus.lint = k;
    bus.red_in = v; bus.green_in = v; bus.blue_in = v; bus.white_in = v;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (pend_active && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    if (pend_active) begin
      n_tests++;
      n_fail++;
      $display("FAIL txn_budget: still pending after %0d cycles, required completion", n);
      pend_active = 1'b0;
    end
  endtask

  function automatic logic [31:0] outs();
    return {bus.red_out, bus.green_out, bus.blue_out, bus.white_out};
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.lint = '0;
    bus.red_in = '0; bus.green_in = '0; bus.blue_in = '0; bus.white_in = '0;
    for (int i = 0; i < 4; i++) begin
      exp_out[i] = 8'h00; pend_in[i] = 8'h00; pend_out[i] = 8'h00;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_literal", {bus.busy, bus.done, bus.err, bus.mult_ld, bus.mult_a, bus.mult_b, outs()}, 64'd0);
    reset  = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Mid-scale factor with rounding ties and extremes
    run_txn(8'd128, 8'd200, 8'd255, 8'd1, 8'd0, 1'b0);
    wait_idle(100);
    check("A_outs", outs(), {8'd100, 8'd128, 8'd1, 8'd0});
    check("A_latency", done_cyc - s_cyc, 13);

    // Full-scale bypass
    run_txn(8'd255, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    wait_idle(100);
    check("B_outs", outs(), 32'h12345678);
    check("B_latency", done_cyc - s_cyc, 9);

    // Zero bypass
    run_txn(8'd0, 8'd9, 8'd8, 8'd7, 8'd6, 1'b0);
    wait_idle(100);
    check("C_outs", outs(), 32'h0);
    check("C_latency", done_cyc - s_cyc, 9);

    // General factor with an ignored start while busy
    run_txn(8'd77, 8'd33, 8'd250, 8'd128, 8'd7, 1'b0);
    repeat (3) @(negedge clk);
    poke_start(8'd5, 8'd99);
    wait_idle(100);
    check("D_outs", outs(), {8'd10, 8'd75, 8'd39, 8'd2});

    // Saturation of an out-of-range product
    force_res = 65535;
    run_txn(8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    wait_idle(100);
    check("E_sat", outs(), 32'hFFFFFFFF);
    force_res = -1;

    // Half-rate clock enable
    half_mode = 1'b1;
    repeat (4) @(negedge clk);
    run_txn(8'd128, 8'd200, 8'd255, 8'd1, 8'd0, 1'b0);
    wait_idle(200);
    check("F_outs", outs(), {8'd100, 8'd128, 8'd1, 8'd0});
    check("F_latency", done_cyc - s_cyc, 26);
    half_mode = 1'b0;
    repeat (4) @(negedge clk);

    // Multiplier never answers: timeout
    mute = 1'b1;
    run_txn(8'd100, 8'd50, 8'd60, 8'd70, 8'd80, 1'b1);
    wait_idle(200);
    mute = 1'b0;
    check("G_err", bus.err, 1'b1);
    check("G_outs_kept", outs(), {8'd100, 8'd128, 8'd1, 8'd0});
    check("G_latency", done_cyc - s_cyc, 65);

    // Next start clears the sticky error
    run_txn(8'd255, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    wait_idle(100);
    check("H_err_cleared", bus.err, 1'b0);
    check("H_outs", outs(), 32'h01020304);

    // Ignored start, then reset while waiting on the multiplier
    mute = 1'b1;
    run_txn(8'd128, 8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
    poke_start(8'd3, 8'd77);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    mute = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    check("I_after_reset", {bus.busy, bus.done, bus.err, outs()}, 35'd0);
    check("I_no_done", done_cyc, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
